// File: rtl/sort_sequencer_pkg.sv
// Shared widths and FSM state type for the sort sequencer and its sorting network.
package sort_sequencer_pkg;

  localparam int NETWORK_WIDTH = 8;
  localparam int INDEX_WIDTH   = 4;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/sort_network.sv
// Combinational full sorting network (odd-even transposition); carries an index tag
// alongside each value so the caller can recover arrival order.
module sort_network
  import sort_sequencer_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int UP   = 1
) (
  input  logic [SIZE-1:0][NETWORK_WIDTH-1:0] data_i,
  input  logic [SIZE-1:0][INDEX_WIDTH-1:0]   index_i,
  output logic [SIZE-1:0][NETWORK_WIDTH-1:0] data_o,
  output logic [SIZE-1:0][INDEX_WIDTH-1:0]   index_o
);

  logic [SIZE-1:0][NETWORK_WIDTH-1:0] d_s;
  logic [SIZE-1:0][INDEX_WIDTH-1:0]   x_s;
  logic [NETWORK_WIDTH-1:0]           lo_d_s, hi_d_s;
  logic [INDEX_WIDTH-1:0]             lo_x_s, hi_x_s;
  logic                               swap_s;

  // SIZE alternating odd/even compare-exchange passes fully sort any input
  always_comb begin
    d_s    = data_i;
    x_s    = index_i;
    lo_d_s = '0;
    hi_d_s = '0;
    lo_x_s = '0;
    hi_x_s = '0;
    swap_s = 1'b0;
    for (int s = 0; s < SIZE; s++) begin
      for (int i = 0; i < SIZE - 1; i++) begin
        lo_d_s = d_s[i];
        hi_d_s = d_s[i+1];
        lo_x_s = x_s[i];
        hi_x_s = x_s[i+1];
        swap_s = ((i % 2) == (s % 2)) &&
                 ((UP != 0) ? (lo_d_s > hi_d_s) : (lo_d_s < hi_d_s));
        d_s[i]   = swap_s ? hi_d_s : lo_d_s;
        d_s[i+1] = swap_s ? lo_d_s : hi_d_s;
        x_s[i]   = swap_s ? hi_x_s : lo_x_s;
        x_s[i+1] = swap_s ? lo_x_s : hi_x_s;
      end
    end
    data_o  = d_s;
    index_o = x_s;
  end

endmodule

// File: rtl/sort_sequencer.sv
// Frame sorter: loads SIZE samples, sorts them in one cycle through sort_network,
// then drains them in order with their arrival index.
module sort_sequencer
  import sort_sequencer_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int UP   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [NETWORK_WIDTH-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [NETWORK_WIDTH-1:0] m_data,
  output logic [INDEX_WIDTH-1:0]   m_index,
  output logic                     m_last,
  output logic                     busy
);

  localparam int             CW   = $clog2(SIZE);
  localparam logic [CW-1:0]  LAST = CW'(SIZE - 1);

  state_e                             state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic                               load_en_s, sort_en_s;
  logic [SIZE-1:0][NETWORK_WIDTH-1:0] slot_q, buf_data_q, net_data_s;
  logic [SIZE-1:0][INDEX_WIDTH-1:0]   buf_idx_q, net_idx_s, tag_s;

  // Slot position is the arrival index, so tags are constants
  always_comb begin
    tag_s = '0;
    for (int i = 0; i < SIZE; i++) begin
      tag_s[i] = INDEX_WIDTH'(i);
    end
  end

  sort_network #(
    .SIZE (SIZE),
    .UP   (UP)
  ) u_net (
    .data_i  (slot_q),
    .index_i (tag_s),
    .data_o  (net_data_s),
    .index_o (net_idx_s)
  );

  // State and shared counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; clear overrides any same-cycle handshake
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_en_s = 1'b0;
    sort_en_s = 1'b0;
    if (clear) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (s_valid) begin
            load_en_s = 1'b1;
            if (cnt_q == LAST) begin
              state_d = ST_SORT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_SORT: begin
          sort_en_s = 1'b1;
          state_d   = ST_DRAIN;
          cnt_d     = '0;
        end
        ST_DRAIN: begin
          if (m_ready) begin
            if (cnt_q == LAST) begin
              state_d = ST_LOAD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Data storage: contents are qualified by state, so no reset is needed
  always_ff @(posedge clk) begin
    if (load_en_s) begin
      slot_q[cnt_q] <= s_data;
    end
    if (sort_en_s) begin
      buf_data_q <= net_data_s;
      buf_idx_q  <= net_idx_s;
    end
  end

  // Outputs decoded from registered state; data forced to zero outside DRAIN
  always_comb begin
    s_ready = (state_q == ST_LOAD);
    m_valid = (state_q == ST_DRAIN);
    busy    = (state_q != ST_LOAD);
    if (state_q == ST_DRAIN) begin
      m_data  = buf_data_q[cnt_q];
      m_index = buf_idx_q[cnt_q];
      m_last  = (cnt_q == LAST);
    end else begin
      m_data  = '0;
      m_index = '0;
      m_last  = 1'b0;
    end
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed bench: ascending and descending instances share stimulus; each task
// drives one scenario and checks outputs against hand-computed values.
module tb_sort_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       m_ready = 1'b0;

  logic       s_ready, m_valid, m_last, busy;
  logic [7:0] m_data;
  logic [3:0] m_index;
  logic       s_ready_d, m_valid_d, m_last_d, busy_d;
  logic [7:0] m_data_d;
  logic [3:0] m_index_d;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_d[4];
  logic [3:0] exp_i[4];
  logic [7:0] dsc_d[4];
  logic [3:0] dsc_i[4];

  always #5 clk = ~clk;

  sort_sequencer #(.SIZE(4), .UP(1)) dut_up (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_index(m_index), .m_last(m_last), .busy(busy)
  );

  sort_sequencer #(.SIZE(4), .UP(0)) dut_dn (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready_d), .s_data(s_data),
    .m_valid(m_valid_d), .m_ready(m_ready), .m_data(m_data_d),
    .m_index(m_index_d), .m_last(m_last_d), .busy(busy_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: s_ready=%b m_valid=%b busy=%b m_last=%b, want 1 0 0 0",
               name, s_ready, m_valid, busy, m_last);
    end
  endtask

  task automatic load(input logic [7:0] v);
    s_valid = 1'b1;
    s_data  = v;
    tick();
    s_valid = 1'b0;
  endtask

  // Loads four samples, checks the SORT cycle, and stops at the first DRAIN cycle
  task automatic load_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    load(a); load(b); load(c); load(d);
    vectors++;
    if (m_valid !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL sort_cycle: m_valid=%b busy=%b s_ready=%b, want 0 1 0", m_valid, busy, s_ready);
    end
    tick();
    vectors++;
    if (m_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL latency: m_valid=%b one cycle after last load, want 1", m_valid);
    end
  endtask

  // Drains one frame against exp_*; optional back-pressure at element hold_at
  task automatic drain(input int hold_at, input int hold_n, input bit chk_dn);
    for (int k = 0; k < 4; k++) begin
      if (k == hold_at) begin
        m_ready = 1'b0;
        for (int h = 0; h < hold_n; h++) begin
          vectors++;
          if (m_valid !== 1'b1 || busy !== 1'b1 || m_data !== exp_d[k] ||
              m_index !== exp_i[k] || m_last !== (k == 3)) begin
            miscompares++;
            $display("FAIL hold[%0d]: got v=%b b=%b (%0d,%0d) last=%b, want v=1 b=1 (%0d,%0d)",
                     h, m_valid, busy, m_data, m_index, m_last, exp_d[k], exp_i[k]);
          end
          tick();
        end
      end
      m_ready = 1'b1;
      vectors++;
      if (m_valid !== 1'b1 || m_data !== exp_d[k] || m_index !== exp_i[k] ||
          m_last !== (k == 3)) begin
        miscompares++;
        $display("FAIL up_elem[%0d]: got v=%b (%0d,%0d) last=%b, want v=1 (%0d,%0d) last=%b",
                 k, m_valid, m_data, m_index, m_last, exp_d[k], exp_i[k], (k == 3));
      end
      if (chk_dn) begin
        vectors++;
        if (m_valid_d !== 1'b1 || m_data_d !== dsc_d[k] || m_index_d !== dsc_i[k] ||
            m_last_d !== (k == 3)) begin
          miscompares++;
          $display("FAIL dn_elem[%0d]: got v=%b (%0d,%0d) last=%b, want v=1 (%0d,%0d) last=%b",
                   k, m_valid_d, m_data_d, m_index_d, m_last_d, dsc_d[k], dsc_i[k], (k == 3));
        end
      end
      tick();
    end
    m_ready = 1'b0;
    check_idle("after_drain");
  endtask

  task automatic test_reset();
    #2;
    check_idle("reset_ctrl");
    vectors++;
    if (m_data !== 8'd0 || m_index !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_data: got (%0d,%0d), want (0,0)", m_data, m_index);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle("post_reset");
  endtask

  task automatic test_sort_both();
    exp_d = '{8'd2, 8'd4, 8'd7, 8'd9}; exp_i = '{4'd1, 4'd3, 4'd0, 4'd2};
    dsc_d = '{8'd9, 8'd7, 8'd4, 8'd2}; dsc_i = '{4'd2, 4'd0, 4'd3, 4'd1};
    m_ready = 1'b1;
    load_frame(8'd7, 8'd2, 8'd9, 8'd4);
    drain(-1, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    exp_d = '{8'd2, 8'd4, 8'd7, 8'd9}; exp_i = '{4'd1, 4'd3, 4'd0, 4'd2};
    load_frame(8'd7, 8'd2, 8'd9, 8'd4);
    drain(1, 3, 1'b0);
  endtask

  task automatic test_clear();
    load(8'd11); load(8'd12);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_idle("clear_partial");
    exp_d = '{8'd1, 8'd3, 8'd5, 8'd8}; exp_i = '{4'd1, 4'd3, 4'd0, 4'd2};
    load_frame(8'd5, 8'd1, 8'd8, 8'd3);
    drain(-1, 0, 1'b0);
  endtask

  task automatic test_reset_in_drain();
    load_frame(8'd7, 8'd2, 8'd9, 8'd4);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("reset_in_drain");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_d = '{8'd1, 8'd3, 8'd5, 8'd8}; exp_i = '{4'd1, 4'd3, 4'd0, 4'd2};
    load_frame(8'd5, 8'd1, 8'd8, 8'd3);
    drain(-1, 0, 1'b0);
  endtask

  task automatic test_clear_on_last();
    load(8'd1); load(8'd2); load(8'd3);
    s_valid = 1'b1;
    s_data  = 8'd4;
    clear   = 1'b1;
    tick();
    s_valid = 1'b0;
    clear   = 1'b0;
    check_idle("clear_last_0");
    tick();
    check_idle("clear_last_1");
    exp_d = '{8'd2, 8'd4, 8'd6, 8'd8}; exp_i = '{4'd3, 4'd0, 4'd2, 4'd1};
    load_frame(8'd4, 8'd8, 8'd6, 8'd2);
    drain(-1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_sort_both();
    test_backpressure();
    test_clear();
    test_reset_in_drain();
    test_clear_on_last();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
